// File: rtl/ctrl_interrupcoes.sv
// ctrl_interrupcoes: four-sensor interrupt controller.
// Rising edges on the sensor inputs are latched into pending flags, one
// eligible source is granted at a time (fixed priority or round-robin),
// and the grant is held until the processor acknowledges it or a watchdog
// abandons it.
module ctrl_interrupcoes #(
   parameter int TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       m,
   input  logic [3:0] sensores,
   input  logic [3:0] mascara,
   input  logic       ack,
   output logic       irq,
   output logic [1:0] id,
   output logic [3:0] pendente,
   output logic       erro_timeout
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      CONCEDIDO = 2'd1,
      LIBERA    = 2'd2
   } estado_t;

   estado_t       estado, estado_nxt;
   logic [3:0]    sens_ant;
   logic [3:0]    borda;
   logic [3:0]    eleg;
   logic [3:0]    limpa;
   logic [1:0]    ultimo, ultimo_nxt;
   logic [CW-1:0] contador, contador_nxt;
   logic          irq_nxt;
   logic [1:0]    id_nxt;
   logic          erro_nxt;
   logic [1:0]    sel_fixo, sel_rr, sel;
   logic          achou;
   logic [1:0]    idx;

   // Masked edges are dropped at capture time; masked pending bits are kept
   // but excluded from arbitration.
   assign borda = sensores & ~sens_ant & mascara;
   assign eleg  = pendente & mascara;

   // Arbitration: highest index for fixed priority, first set bit after the
   // last serviced source (wrapping) for round-robin.
   always_comb begin
      sel_fixo = 2'd0;
      sel_rr   = 2'd0;
      achou    = 1'b0;
      idx      = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (eleg[i]) sel_fixo = 2'(i);
      end
      for (int k = 1; k <= 4; k++) begin
         idx = ultimo + 2'(k);
         if (!achou && eleg[idx]) begin
            sel_rr = idx;
            achou  = 1'b1;
         end
      end
      sel = m ? sel_rr : sel_fixo;
   end

   // Next-state and next-output logic for the grant handshake.
   always_comb begin
      estado_nxt   = estado;
      irq_nxt      = irq;
      id_nxt       = id;
      contador_nxt = contador;
      ultimo_nxt   = ultimo;
      erro_nxt     = 1'b0;
      limpa        = 4'b0000;
      case (estado)
         OCIOSO: begin
            irq_nxt = 1'b0;
            if (eleg != 4'b0000) begin
               id_nxt       = sel;
               irq_nxt      = 1'b1;
               contador_nxt = '0;
               estado_nxt   = CONCEDIDO;
            end
         end
         CONCEDIDO: begin
            contador_nxt = contador + CW'(1);
            if (ack) begin
               // ack beats a coincident timeout
               limpa      = 4'b0001 << id;
               ultimo_nxt = id;
               irq_nxt    = 1'b0;
               estado_nxt = LIBERA;
            end else if (contador == CW'(TIMEOUT - 1)) begin
               // abandon the grant but keep the request pending; moving
               // ultimo lets round-robin step past a stuck source
               erro_nxt   = 1'b1;
               ultimo_nxt = id;
               irq_nxt    = 1'b0;
               estado_nxt = LIBERA;
            end
         end
         LIBERA: begin
            irq_nxt = 1'b0;
            if (!ack) estado_nxt = OCIOSO;
         end
         default: begin
            irq_nxt    = 1'b0;
            estado_nxt = OCIOSO;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= estado_nxt;
   end

   // Registered outputs, edge history and pending flags; a new edge wins
   // over a same-cycle clear so the event is not lost.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq          <= 1'b0;
         id           <= 2'd0;
         pendente     <= 4'b0000;
         erro_timeout <= 1'b0;
         sens_ant     <= 4'b0000;
         ultimo       <= 2'd3;
         contador     <= '0;
      end else begin
         irq          <= irq_nxt;
         id           <= id_nxt;
         pendente     <= (pendente & ~limpa) | borda;
         erro_timeout <= erro_nxt;
         sens_ant     <= sensores;
         ultimo       <= ultimo_nxt;
         contador     <= contador_nxt;
      end
   end

endmodule

// File: tb/tb_ctrl_interrupcoes.sv
// Bench for ctrl_interrupcoes: directed scenarios with constant
// expectations, then a randomized run against a behavioural model.
module tb_ctrl_interrupcoes;

   localparam int TO = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       m = 1'b0;
   logic [3:0] sensores = 4'b0000;
   logic [3:0] mascara = 4'b1111;
   logic       ack = 1'b0;
   logic       irq;
   logic [1:0] id;
   logic [3:0] pendente;
   logic       erro_timeout;

   int n_chk = 0;
   int n_fail = 0;

   // behavioural model: 0 idle, 1 granted, 2 release
   int       mst;
   bit [3:0] m_pend, m_prev;
   int       m_last, m_cnt, m_id;
   bit       m_irq, m_err;

   ctrl_interrupcoes #(.TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .m(m), .sensores(sensores),
      .mascara(mascara), .ack(ack), .irq(irq), .id(id),
      .pendente(pendente), .erro_timeout(erro_timeout)
   );

   always #5 clock = ~clock;

   function automatic void model_reset();
      mst = 0; m_pend = 4'b0; m_prev = 4'b0; m_last = 3; m_cnt = 0;
      m_id = 0; m_irq = 1'b0; m_err = 1'b0;
   endfunction

   function automatic int model_pick(bit [3:0] el);
      if (!m) begin
         for (int i = 3; i >= 0; i--) if (el[i]) return i;
      end else begin
         for (int k = 1; k <= 4; k++) if (el[(m_last + k) % 4]) return (m_last + k) % 4;
      end
      return 0;
   endfunction

   function automatic void model_step();
      bit [3:0] edges, clr, el;
      edges = sensores & ~m_prev & mascara;
      clr = 4'b0;
      m_err = 1'b0;
      if (mst == 0) begin
         el = m_pend & mascara;
         if (el != 0) begin
            m_id = model_pick(el); m_irq = 1'b1; m_cnt = 0; mst = 1;
         end
      end else if (mst == 1) begin
         if (ack) begin
            clr[m_id] = 1'b1; m_last = m_id; m_irq = 1'b0; mst = 2;
         end else if (m_cnt == TO - 1) begin
            m_err = 1'b1; m_last = m_id; m_irq = 1'b0; mst = 2;
         end else begin
            m_cnt++;
         end
      end else begin
         if (!ack) mst = 0;
      end
      m_pend = (m_pend & ~clr) | edges;
      m_prev = sensores;
   endfunction

   // one clock edge, model advanced with the same inputs, then settle
   task automatic tick();
      @(posedge clock);
      if (reset) model_reset(); else model_step();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; sensores = 4'b0; ack = 1'b0;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_chk++;
      if ({irq, id, pendente, erro_timeout} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_state: got irq=%0b id=%0d pend=%b err=%0b expected all zero",
                  irq, id, pendente, erro_timeout);
      end
      @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_fixed_priority();
      do_reset();
      m = 1'b0; mascara = 4'b1111; sensores = 4'b0101;
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0101) begin
         n_fail++; $display("FAIL fp_capture: got irq=%0b pend=%b expected 0 0101", irq, pendente);
      end
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_10) begin
         n_fail++; $display("FAIL fp_grant_sc: got irq=%0b id=%0d expected 1 2", irq, id);
      end
      ack = 1'b1;
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0001) begin
         n_fail++; $display("FAIL fp_ack_sc: got irq=%0b pend=%b expected 0 0001", irq, pendente);
      end
      ack = 1'b0; sensores = 4'b0000;
      tick();
      n_chk++;
      if (irq !== 1'b0) begin
         n_fail++; $display("FAIL fp_gap: got irq=%0b expected 0", irq);
      end
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_00) begin
         n_fail++; $display("FAIL fp_grant_sa: got irq=%0b id=%0d expected 1 0", irq, id);
      end
      ack = 1'b1;
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0000) begin
         n_fail++; $display("FAIL fp_ack_sa: got irq=%0b pend=%b expected 0 0000", irq, pendente);
      end
      ack = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      int exp_id[5] = '{0, 1, 2, 3, 0};
      do_reset();
      m = 1'b1; mascara = 4'b1111; sensores = 4'b1111;
      tick();
      tick();
      for (int g = 0; g < 5; g++) begin
         n_chk++;
         if ({irq, id, pendente} !== {1'b1, 2'(exp_id[g]), 4'b1111}) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got irq=%0b id=%0d pend=%b expected 1 %0d 1111",
                     g, irq, id, pendente, exp_id[g]);
         end
         ack = 1'b1;
         sensores[exp_id[g]] = 1'b0;
         tick();
         n_chk++;
         if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rr_release%0d: got irq=%0b expected 0", g, irq);
         end
         ack = 1'b0;
         sensores[exp_id[g]] = 1'b1;
         tick();
         tick();
      end
   endtask

   task automatic test_timeout();
      do_reset();
      m = 1'b0; mascara = 4'b1111; sensores = 4'b0010;
      tick();
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_01) begin
         n_fail++; $display("FAIL to_grant: got irq=%0b id=%0d expected 1 1", irq, id);
      end
      for (int c = 0; c < TO - 1; c++) begin
         tick();
         n_chk++;
         if ({irq, erro_timeout} !== 2'b10) begin
            n_fail++;
            $display("FAIL to_hold%0d: got irq=%0b err=%0b expected 1 0", c, irq, erro_timeout);
         end
      end
      tick();
      n_chk++;
      if ({irq, erro_timeout, pendente} !== 6'b0_1_0010) begin
         n_fail++;
         $display("FAIL to_expire: got irq=%0b err=%0b pend=%b expected 0 1 0010",
                  irq, erro_timeout, pendente);
      end
      tick();
      n_chk++;
      if ({irq, erro_timeout} !== 2'b00) begin
         n_fail++; $display("FAIL to_pulse_end: got irq=%0b err=%0b expected 0 0", irq, erro_timeout);
      end
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_01) begin
         n_fail++; $display("FAIL to_regrant: got irq=%0b id=%0d expected 1 1", irq, id);
      end
   endtask

   task automatic test_masking();
      do_reset();
      m = 1'b0; mascara = 4'b1110; sensores = 4'b0001;
      tick();
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0000) begin
         n_fail++; $display("FAIL mask_lost: got irq=%0b pend=%b expected 0 0000", irq, pendente);
      end
      sensores = 4'b0101;
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0100) begin
         n_fail++; $display("FAIL mask_capture: got irq=%0b pend=%b expected 0 0100", irq, pendente);
      end
      mascara = 4'b1010;
      tick();
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0100) begin
         n_fail++; $display("FAIL mask_retain: got irq=%0b pend=%b expected 0 0100", irq, pendente);
      end
      mascara = 4'b1110;
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_10) begin
         n_fail++; $display("FAIL mask_unmask: got irq=%0b id=%0d expected 1 2", irq, id);
      end
   endtask

   task automatic test_collision();
      do_reset();
      m = 1'b0; mascara = 4'b1111; sensores = 4'b1000;
      tick();
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_11) begin
         n_fail++; $display("FAIL col_grant: got irq=%0b id=%0d expected 1 3", irq, id);
      end
      sensores = 4'b0000;
      tick();
      ack = 1'b1; sensores = 4'b1000;
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_1000) begin
         n_fail++; $display("FAIL col_keep: got irq=%0b pend=%b expected 0 1000", irq, pendente);
      end
      ack = 1'b0;
      tick();
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_11) begin
         n_fail++; $display("FAIL col_regrant: got irq=%0b id=%0d expected 1 3", irq, id);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      m = 1'b0; mascara = 4'b1111; sensores = 4'b0100;
      tick();
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_10) begin
         n_fail++; $display("FAIL ar_grant: got irq=%0b id=%0d expected 1 2", irq, id);
      end
      #2 reset = 1'b1;
      #1;
      n_chk++;
      if ({irq, pendente, erro_timeout} !== 6'b0) begin
         n_fail++;
         $display("FAIL ar_clear: got irq=%0b pend=%b err=%0b expected 0 0000 0",
                  irq, pendente, erro_timeout);
      end
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      tick();
      n_chk++;
      if ({irq, pendente} !== 5'b0_0100) begin
         n_fail++; $display("FAIL ar_recapture: got irq=%0b pend=%b expected 0 0100", irq, pendente);
      end
      tick();
      n_chk++;
      if ({irq, id} !== 3'b1_10) begin
         n_fail++; $display("FAIL ar_regrant: got irq=%0b id=%0d expected 1 2", irq, id);
      end
   endtask

   task automatic test_random();
      do_reset();
      m = 1'b1; mascara = 4'b1111;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0) sensores = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) mascara = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 31) == 0) m = ~m;
         ack = ($urandom_range(0, 3) == 0);
         tick();
         n_chk++;
         if ({irq, pendente, erro_timeout} !== {m_irq, m_pend, m_err}) begin
            n_fail++;
            $display("FAIL rnd_state c%0d: got irq=%0b pend=%b err=%0b expected %0b %b %0b",
                     c, irq, pendente, erro_timeout, m_irq, m_pend, m_err);
         end
         if (m_irq) begin
            n_chk++;
            if (id !== 2'(m_id)) begin
               n_fail++; $display("FAIL rnd_id c%0d: got id=%0d expected %0d", c, id, m_id);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_timeout();
      test_masking();
      test_collision();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
